// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module   : mult_div_unit
//  Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] c_multLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_divLoad  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cntOne   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            r_state, w_stateNext;
  logic [CNT_W-1:0]  r_count, w_countNext;
  logic [31:0]       r_hi, r_lo, w_hiNext, w_loNext;
  logic [31:0]       r_pendHi, r_pendLo, w_pendHiNext, w_pendLoNext;
  logic              r_pendValid, w_pendValidNext;

  // Result datapath; operands are consumed only on the start edge.
  logic signed [63:0] w_prodS;
  logic        [63:0] w_prodU;
  logic               w_divByZero;
  logic               w_divOvf;
  logic        [31:0] w_divisor;
  logic signed [31:0] w_quotS, w_remS;
  logic        [31:0] w_quotU, w_remU;

  assign w_prodS     = $signed({{32{busA[31]}}, busA}) * $signed({{32{busB[31]}}, busB});
  assign w_prodU     = {32'd0, busA} * {32'd0, busB};
  assign w_divByZero = (busB == 32'd0);
  assign w_divOvf    = (busA == 32'h8000_0000) && (busB == 32'hFFFF_FFFF);
  // Substitute a divisor of 1 so the dividers never see zero; the result is discarded anyway.
  assign w_divisor   = w_divByZero ? 32'd1 : busB;
  assign w_quotS     = $signed(busA) / $signed(w_divisor);
  assign w_remS      = $signed(busA) % $signed(w_divisor);
  assign w_quotU     = busA / w_divisor;
  assign w_remU      = busA % w_divisor;

  always_comb begin
    w_stateNext     = r_state;
    w_countNext     = r_count;
    w_hiNext        = r_hi;
    w_loNext        = r_lo;
    w_pendHiNext    = r_pendHi;
    w_pendLoNext    = r_pendLo;
    w_pendValidNext = r_pendValid;

    case (r_state)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT: begin
              w_pendHiNext    = w_prodS[63:32];
              w_pendLoNext    = w_prodS[31:0];
              w_pendValidNext = 1'b1;
              w_countNext     = c_multLoad;
              w_stateNext     = RUN;
            end
            OP_MULTU: begin
              w_pendHiNext    = w_prodU[63:32];
              w_pendLoNext    = w_prodU[31:0];
              w_pendValidNext = 1'b1;
              w_countNext     = c_multLoad;
              w_stateNext     = RUN;
            end
            OP_DIV: begin
              // Most-negative / -1 overflows the quotient; defined as wrap with zero remainder.
              w_pendHiNext    = w_divOvf ? 32'd0 : w_remS;
              w_pendLoNext    = w_divOvf ? 32'h8000_0000 : w_quotS;
              w_pendValidNext = !w_divByZero;
              w_countNext     = c_divLoad;
              w_stateNext     = RUN;
            end
            OP_DIVU: begin
              w_pendHiNext    = w_remU;
              w_pendLoNext    = w_quotU;
              w_pendValidNext = !w_divByZero;
              w_countNext     = c_divLoad;
              w_stateNext     = RUN;
            end
            OP_MTHI: w_hiNext = busA;
            OP_MTLO: w_loNext = busA;
            default: ;
          endcase
        end
      end
      RUN: begin
        w_countNext = r_count - c_cntOne;
        if (r_count == c_cntOne) begin
          if (r_pendValid) begin
            w_hiNext = r_pendHi;
            w_loNext = r_pendLo;
          end
          w_pendValidNext = 1'b0;
          w_stateNext     = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pendHi    <= 32'd0;
      r_pendLo    <= 32'd0;
      r_pendValid <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_count     <= w_countNext;
      r_hi        <= w_hiNext;
      r_lo        <= w_loNext;
      r_pendHi    <= w_pendHiNext;
      r_pendLo    <= w_pendLoNext;
      r_pendValid <= w_pendValidNext;
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module   : tb_mult_div_unit
//  Brief    : Scoreboard bench for mult_div_unit (expected HI/LO queued at issue).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'b000;
  logic [31:0] busA = 32'd0;
  logic [31:0] busB = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] expHi   = 32'd0;
  logic [31:0] expLo   = 32'd0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .busA  (busA),
    .busB  (busB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mdop  = op;
    busA  = a;
    busB  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pushExp(input string tag, input logic [31:0] h, input logic [31:0] l,
                         input int cyc);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.cycles = cyc;
    sb.push_back(e);
    expHi = h;
    expLo = l;
  endtask

  // Counts busy cycles after an issue, optionally pulsing a stray start in busy cycle injCyc.
  task automatic waitResult(input int injCyc, input logic [2:0] injOp,
                            input logic [31:0] injA, input logic [31:0] injB);
    int   cnt;
    exp_t e;
    cnt = 0;
    @(negedge clk);
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == injCyc) begin
        start = 1'b1; mdop = injOp; busA = injA; busB = injB;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      checkEq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkEq({e.tag, "_busy_cycles"}, 32'(cnt), 32'(e.cycles));
      checkEq({e.tag, "_hi"}, hi, e.hi);
      checkEq({e.tag, "_lo"}, lo, e.lo);
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkEq("reset_hi", hi, 32'd0);
    checkEq("reset_lo", lo, 32'd0);
    checkEq("reset_busy", 32'(busy), 32'd0);

    // Signed and unsigned multiplies, issued back-to-back.
    pushExp("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    waitResult(0, OP_NOP, 0, 0);
    pushExp("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitResult(0, OP_NOP, 0, 0);

    // Signed divides including the overflow corner, then divide-by-zero.
    pushExp("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitResult(0, OP_NOP, 0, 0);
    pushExp("divu_by_zero", expHi, expLo, 10);
    issue(OP_DIVU, 32'd7, 32'd0);
    waitResult(0, OP_NOP, 0, 0);
    pushExp("div_7_neg2", 32'd1, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    waitResult(0, OP_NOP, 0, 0);
    pushExp("div_ovf", 32'd0, 32'h8000_0000, 10);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitResult(0, OP_NOP, 0, 0);
    pushExp("div_by_zero", expHi, expLo, 10);
    issue(OP_DIV, 32'h1234_5678, 32'd0);
    waitResult(0, OP_NOP, 0, 0);

    // Move-to ops and a no-op while idle.
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    expHi = 32'h1234_5678;
    @(negedge clk);
    checkEq("mthi_hi", hi, expHi);
    checkEq("mthi_lo", lo, expLo);
    checkEq("mthi_busy", 32'(busy), 32'd0);
    issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
    expLo = 32'hCAFE_F00D;
    @(negedge clk);
    checkEq("mtlo_lo", lo, expLo);
    checkEq("mtlo_hi", hi, expHi);
    issue(OP_NOP, 32'hDEAD_BEEF, 32'd1);
    @(negedge clk);
    checkEq("nop_busy", 32'(busy), 32'd0);
    checkEq("nop_hi", hi, expHi);
    checkEq("nop_lo", lo, expLo);

    // Starts during RUN are ignored, operand changes included.
    pushExp("mult_mthi_ignored", 32'd0, 32'd42, 5);
    issue(OP_MULT, 32'd6, 32'd7);
    waitResult(2, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    pushExp("mult_3x4_div_ignored", 32'd0, 32'd12, 5);
    issue(OP_MULT, 32'd3, 32'd4);
    waitResult(2, OP_DIV, 32'd1000, 32'd3);

    // Random unsigned ops checked against plain 64-bit arithmetic.
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      pushExp("multu_rand", p[63:32], p[31:0], 5);
      issue(OP_MULTU, a, b);
      waitResult(0, OP_NOP, 0, 0);
      b = b >> (i * 7);
      if (b == 32'd0) b = 32'd3;
      pushExp("divu_rand", a % b, a / b, 10);
      issue(OP_DIVU, a, b);
      waitResult(0, OP_NOP, 0, 0);
    end

    // Reset during a divide aborts it and the result never lands.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkEq("abort_busy", 32'(busy), 32'd0);
    checkEq("abort_hi", hi, 32'd0);
    checkEq("abort_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    checkEq("abort_late_hi", hi, 32'd0);
    checkEq("abort_late_lo", lo, 32'd0);
    checkEq("abort_late_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
